alu_issue: RTL
==============

# alu_issue

Decode-and-issue stage that feeds the 64-bit ALU. It accepts an RV64I instruction word with its register operands, and decodes opcode/funct3/funct7 into the 4-bit `ALU_Select` code the ALU consumes. It generates and sign-extends the immediate, selects the second operand, and presents `data1`/`data2`/`ALU_Select` through a 2-entry valid/ready buffer. It sits between register read and the ALU.

## Interface
- `n`, 64: operand/result width; must be ≥ 32.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: upstream offers an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `instr` input 32: RV64I instruction word.
- `rs1_data` input n: register operand 1.
- `rs2_data` input n: register operand 2.
- `out_valid` output 1: issued entry present.
- `out_ready` input 1: ALU side consumes the entry.
- `data1` output n: ALU operand 1.
- `data2` output n: ALU operand 2 (rs2 or immediate).
- `ALU_Select` output 4: ALU operation code.
- `illegal` output 1: entry came from an unsupported encoding.
- `illegal_count` output 16: saturating count of illegal instructions accepted.

## Operation
- ALU codes:
  - AND = 0000
  - OR = 0001
  - ADD = 0010
  - SUB = 0110
  - PASS2 = 0111
  - NOR = 1100 (never generated)
- R-type, opcode 0110011, data2 = rs2:
  - f3 000, f7 0000000 → ADD.
  - f3 000, f7 0100000 → SUB.
  - f3 111, f7 0 → AND.
  - f3 110, f7 0 → OR.
- I-ALU, opcode 0010011, data2 = sext(instr[31:20]):
  - f3 000 → ADD.
  - f3 111 → AND.
  - f3 110 → OR.
- Load `ld`, opcode 0000011, f3 011: ADD, data2 = sext(instr[31:20]).
- Store `sd`, opcode 0100011, f3 011: ADD, data2 = sext({instr[31:25], instr[11:7]}).
- Branch `beq`, opcode 1100011, f3 000: SUB, data2 = rs2.
- `lui`, opcode 0110111: PASS2, data2 = sext({instr[31:12], 12'b0}).
- All other encodings are illegal:
  - The entry still issues with `illegal`=1, `ALU_Select`=0000, data1=data2=0.
  - `illegal_count` increments on accept and saturates at 16'hFFFF.
- `data1` = `rs1_data` for every legal op.
- Sign extension replicates the immediate's top bit up to bit n-1.
- Buffer: 2-entry FIFO of decoded entries, occupancy counter 0..2.
  - Accept when `in_valid & in_ready`.
  - Pop when `out_valid & out_ready`.
- `in_ready` = (count < 2). It depends on registered state only, with no combinational path from `out_ready`.
- `out_valid` = (count > 0). Outputs always show the head entry; they hold stable while `out_valid & !out_ready`.
- Simultaneous accept and pop:
  - At count 1, count stays 1, head advances, new entry becomes tail.
  - At count 0, no pop is possible, so count becomes 1.
  - At count 2, no accept is possible, so count becomes 1.
- Reset, including mid-operation:
  - Count cleared to 0; all buffered entries discarded.
  - `out_valid`=0, `in_ready`=1.
  - data1, data2, `ALU_Select`, `illegal` read 0.
  - `illegal_count`=0.

## Timing
- Latency: an instruction accepted at edge k is visible on the outputs with `out_valid`=1 after edge k (cycle k+1) when the buffer was empty.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- Decode is combinational on the input side, and the result is registered into the buffer. No combinational input→output path exists.
- `illegal_count` updates on the same edge as the accept.

## Structure
- Shared package `alu_pkg`:
  - localparams for the six ALU_Select codes and for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111.
  - A packed typedef `alu_issue_entry_t` {data1, data2, sel, illegal}, parameterised on n via a package-level width constant.
- Sub-module `alu_decode` (combinational): instr, rs1_data, rs2_data → entry. The top-level `alu_issue` holds the 2-entry storage, read/write pointers, count and illegal counter.

## Test plan
- Reset, then `add` (0x00B50533), rs1=5, rs2=7, `out_ready`=1 → next cycle: `out_valid`=1, ALU_Select=0010, data1=5, data2=7, `illegal`=0.
- `addi` imm=-1 (0xFFF50513), rs1=10 → data2=64'hFFFF_FFFF_FFFF_FFFF, ALU_Select=0010. Then `sub` (0x40B50533) → ALU_Select=0110, data2=rs2.
- `sd` with S-imm=-8 (instr[31:25]=1111111, instr[11:7]=11000) → data2=64'hFFFF_FFFF_FFFF_FFF8, ALU_Select=0010. `lui` 0x12345 → data2=64'h0000_0000_1234_5000, ALU_Select=0111.
- Backpressure:
  - `out_ready`=0 while pushing 3 instructions → first two accepted, `in_ready`=0 on the third, outputs hold entry 1.
  - Raise `out_ready` → entries drain in order.
  - A simultaneous push/pop at count 1 keeps count 1.
- Illegal encoding 0x0000007F → issues with `illegal`=1, ALU_Select=0000, data1=data2=0, `illegal_count`=1. Sending 65536 illegal instructions saturates the count at 16'hFFFF.
- Assert `reset` with 2 entries buffered → next cycle `out_valid`=0, `in_ready`=1, `illegal_count`=0, outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU decode-and-issue slice.
//   - ALU_Select operation codes consumed by the 64-bit ALU
//   - RV64I major opcodes recognised by the decoder
//   - alu_issue_entry_t: one decoded entry as it sits in the issue buffer
//   - sext12(): sign-extend a 12-bit immediate to the datapath width
package alu_pkg;

  // Datapath width carried by a buffered entry. alu_issue's n must match it.
  localparam int ALU_N = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASS2 = 4'b0111;
  // Understood by the ALU, but nothing in RV64I maps onto it here.
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [ALU_N-1:0] data1;
    logic [ALU_N-1:0] data2;
    logic [3:0]       sel;
    logic             illegal;
  } alu_issue_entry_t;

  function automatic logic [ALU_N-1:0] sext12(input logic [11:0] imm);
    return {{(ALU_N-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational RV64I decoder for the ALU issue stage.
// Ports:
//   instr    in  32     instruction word
//   rs1_data in  ALU_N  register operand 1
//   rs2_data in  ALU_N  register operand 2
//   entry    out        decoded {data1, data2, sel, illegal}
// Unsupported encodings produce an all-zero entry with illegal set, so the
// ALU sees a harmless AND of zeros if it ever consumes one.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]      instr,
  input  logic [ALU_N-1:0] rs1_data,
  input  logic [ALU_N-1:0] rs2_data,
  output alu_issue_entry_t entry
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             legal;
  logic [3:0]       sel;
  logic [ALU_N-1:0] data2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    legal = 1'b0;
    sel   = ALU_AND;
    data2 = '0;
    case (opcode)
      OP_R: begin
        data2 = rs2_data;
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          legal = 1'b1;
          sel   = ALU_ADD;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal = 1'b1;
          sel   = ALU_SUB;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
          legal = 1'b1;
          sel   = ALU_AND;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
          legal = 1'b1;
          sel   = ALU_OR;
        end
      end
      OP_IMM: begin
        data2 = sext12(instr[31:20]);
        case (funct3)
          3'b000: begin legal = 1'b1; sel = ALU_ADD; end
          3'b111: begin legal = 1'b1; sel = ALU_AND; end
          3'b110: begin legal = 1'b1; sel = ALU_OR;  end
          default: ;
        endcase
      end
      OP_LOAD: begin
        data2 = sext12(instr[31:20]);
        if (funct3 == 3'b011) begin
          legal = 1'b1;
          sel   = ALU_ADD;
        end
      end
      OP_STORE: begin
        // S-type immediate is split around the rs2/rs1/funct3 fields.
        data2 = sext12({instr[31:25], instr[11:7]});
        if (funct3 == 3'b011) begin
          legal = 1'b1;
          sel   = ALU_ADD;
        end
      end
      OP_BRANCH: begin
        data2 = rs2_data;
        if (funct3 == 3'b000) begin
          legal = 1'b1;
          sel   = ALU_SUB;
        end
      end
      OP_LUI: begin
        legal = 1'b1;
        sel   = ALU_PASS2;
        data2 = {{(ALU_N-32){instr[31]}}, instr[31:12], 12'b0};
      end
      default: ;
    endcase

    if (legal) begin
      entry.data1   = rs1_data;
      entry.data2   = data2;
      entry.sel     = sel;
      entry.illegal = 1'b0;
    end else begin
      entry.data1   = '0;
      entry.data2   = '0;
      entry.sel     = ALU_AND;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage between register read and the ALU.
// Decodes the incoming instruction, registers the result into a 2-entry
// valid/ready buffer and presents the head entry to the ALU.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            upstream handshake
//   instr, rs1_data, rs2_data    instruction and register operands
//   out_valid/out_ready          ALU-side handshake
//   data1, data2, ALU_Select     head entry operands and operation code
//   illegal                      head entry came from an unsupported encoding
//   illegal_count                saturating count of illegal instructions accepted
module alu_issue
  import alu_pkg::*;
#(
  parameter int n = ALU_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [n-1:0] rs1_data,
  input  logic [n-1:0] rs2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] data1,
  output logic [n-1:0] data2,
  output logic [3:0]   ALU_Select,
  output logic         illegal,
  output logic [15:0]  illegal_count
);

  alu_issue_entry_t dec_entry;
  alu_issue_entry_t head_entry;
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [15:0]      illegal_count_reg;
  logic             accept;
  logic             pop;

  alu_decode u_decode (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .entry    (dec_entry)
  );

  // Handshake flags come only from the occupancy register, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      alu_issue_entry_t slot_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_reg <= '0;
        end else if (accept && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= dec_entry;
        end
      end
    end
  endgenerate

  assign head_entry = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;

  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
      illegal_count_reg <= 16'd0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      if (accept && dec_entry.illegal && (illegal_count_reg != 16'hFFFF)) begin
        illegal_count_reg <= illegal_count_reg + 16'd1;
      end
    end
  end

  // An empty buffer presents zeros rather than a stale, already-consumed entry.
  assign data1         = out_valid ? head_entry.data1   : '0;
  assign data2         = out_valid ? head_entry.data2   : '0;
  assign ALU_Select    = out_valid ? head_entry.sel     : 4'b0000;
  assign illegal       = out_valid ? head_entry.illegal : 1'b0;
  assign illegal_count = illegal_count_reg;

endmodule
